// File: rtl/mul_inner_acc.sv
// mul_inner_acc: unary rate-coded multiplier PE cell with random forwarding and a windowed ones counter.
module mul_inner_acc #(
    parameter int WIDTH = 8,
    parameter int LENW  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [LENW-1:0]  i_len,
    input  logic [WIDTH-2:0] i_data_w,
    input  logic             i_en,
    input  logic             i_bit_i,
    input  logic [WIDTH-2:0] i_randW,
    output logic [WIDTH-2:0] o_randW,
    output logic             o_bit,
    output logic             o_busy,
    output logic             o_done,
    output logic [LENW-1:0]  o_acc
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-2:0] w_q, rand_q;
    logic             mode_q;
    logic [LENW-1:0]  len_q, cnt_q, acc_q, cnt_d, acc_d;
    logic             bit_w, accept;
    // weight bit compares against the forwarded (registered) random number
    assign bit_w   = w_q > rand_q;
    assign o_bit   = (state_q == RUN) && i_en && (mode_q ? ~(i_bit_i ^ bit_w) : (i_bit_i & bit_w));
    assign accept  = i_start && (state_q != RUN);
    assign cnt_d   = cnt_q + 1'b1;
    assign acc_d   = acc_q + {{(LENW-1){1'b0}}, o_bit};
    assign o_randW = rand_q;
    assign o_acc   = acc_q;
    assign o_busy  = state_q == RUN;
    assign o_done  = state_q == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rand_q  <= '0;
            w_q     <= '0;
            mode_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            rand_q <= i_randW;
            if (accept) begin
                w_q     <= i_data_w;
                mode_q  <= i_mode;
                len_q   <= i_len;
                cnt_q   <= '0;
                acc_q   <= '0;
                state_q <= (i_len == '0) ? DONE : RUN;
            end else if (state_q == RUN && i_en) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
                if (cnt_q == len_q - 1'b1) state_q <= DONE;
            end else if (state_q == DONE) begin
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mul_inner_acc.sv
// tb_mul_inner_acc: randomized scenarios checked against a window-level behavioural model.
module tb_mul_inner_acc;
    logic       clk = 1'b0;
    logic       rst, i_start, i_mode, i_en, i_bit_i;
    logic [7:0] i_len, o_acc;
    logic [6:0] i_data_w, i_randW, o_randW;
    logic       o_bit, o_busy, o_done;
    int n_cmp = 0;
    int n_err = 0;
    // model: running/done flags, enabled cycles remaining, ones so far, latched params
    bit m_run, m_done, m_mode;
    int m_rem, m_acc, m_w, m_rand;
    bit last_done, last_bit, last_busy;
    int last_acc, last_rand;

    always #5 clk = ~clk;

    mul_inner_acc #(.WIDTH(8), .LENW(8)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_len(i_len),
        .i_data_w(i_data_w), .i_en(i_en), .i_bit_i(i_bit_i), .i_randW(i_randW),
        .o_randW(o_randW), .o_bit(o_bit), .o_busy(o_busy), .o_done(o_done), .o_acc(o_acc)
    );

    task automatic cyc(input bit rs, input bit st, input bit md, input int ln, input int w,
                       input bit en, input bit b, input int r);
        bit exp_bit, wb;
        rst = rs; i_start = st; i_mode = md; i_len = 8'(ln); i_data_w = 7'(w);
        i_en = en; i_bit_i = b; i_randW = 7'(r);
        #1;
        wb = m_w > m_rand;
        exp_bit = (m_run && en) ? (m_mode ? (b == wb) : (b && wb)) : 1'b0;
        n_cmp += 5;
        if (o_bit !== exp_bit) begin n_err++; $display("FAIL o_bit: got %b want %b at %0t", o_bit, exp_bit, $time); end
        if (o_busy !== m_run) begin n_err++; $display("FAIL o_busy: got %b want %b at %0t", o_busy, m_run, $time); end
        if (o_done !== m_done) begin n_err++; $display("FAIL o_done: got %b want %b at %0t", o_done, m_done, $time); end
        if (o_acc !== 8'(m_acc)) begin n_err++; $display("FAIL o_acc: got %0d want %0d at %0t", o_acc, m_acc, $time); end
        if (o_randW !== 7'(m_rand)) begin n_err++; $display("FAIL o_randW: got %0d want %0d at %0t", o_randW, m_rand, $time); end
        last_done = o_done; last_acc = int'(o_acc); last_bit = o_bit; last_busy = o_busy; last_rand = int'(o_randW);
        if (rs) begin
            m_run = 0; m_done = 0; m_mode = 0; m_rem = 0; m_acc = 0; m_w = 0; m_rand = 0;
        end else begin
            if (st && !m_run) begin
                m_w = w; m_mode = md; m_acc = 0;
                m_run = (ln != 0); m_done = (ln == 0); m_rem = ln;
            end else if (m_run) begin
                if (en) begin
                    m_acc += int'(exp_bit);
                    m_rem--;
                    if (m_rem == 0) begin m_run = 0; m_done = 1; end
                end
            end else m_done = 0;
            m_rand = r;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1; i_start = 0; i_en = 0; i_bit_i = 0; i_mode = 0; i_len = 0; i_data_w = 0; i_randW = 7'd55;
        @(posedge clk); #1;
        m_run = 0; m_done = 0; m_mode = 0; m_rem = 0; m_acc = 0; m_w = 0; m_rand = 0;
        n_cmp++;
        if ({o_busy, o_done, o_acc, o_randW} !== 17'd0) begin
            n_err++; $display("FAIL reset: got busy=%b done=%b acc=%0d rand=%0d want all 0", o_busy, o_done, o_acc, o_randW);
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ramp_window(input string name, input bit md, input int w, input bit b, input int want);
        int k;
        cyc(0, 1, md, 128, w, 1, b, 0);
        for (k = 1; k <= 300; k++) begin
            cyc(0, 0, 0, 0, 0, 1, b, k < 128 ? k : int'($urandom_range(127)));
            if (k <= 128 && last_rand != k - 1) begin
                n_err++; $display("FAIL %s rand lag: got %0d want %0d", name, last_rand, k - 1);
            end
            if (last_done) break;
        end
        n_cmp += 2;
        if (k != 129) begin n_err++; $display("FAIL %s done cycle: got %0d want 129", name, k); end
        if (last_acc != want) begin n_err++; $display("FAIL %s acc: got %0d want %0d", name, last_acc, want); end
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_unipolar;
        ramp_window("uni", 0, 64, 1, 64);
    endtask

    task automatic test_bipolar;
        ramp_window("bip_b0", 1, 64, 0, 64);
        ramp_window("bip_b1", 1, 64, 1, 64);
        ramp_window("bip_w0", 1, 0, 0, 128);
    endtask

    task automatic test_enable_gaps;
        int k;
        bit en;
        cyc(0, 1, 0, 16, 127, 1, 1, $urandom_range(126));
        for (k = 1; k <= 100; k++) begin
            en = k[0];
            cyc(0, 0, 0, 0, 0, en, 1, $urandom_range(126));
            if (!en && last_bit) begin n_err++; $display("FAIL gap o_bit: got 1 want 0 at k=%0d", k); end
            if (last_done) break;
        end
        n_cmp += 2;
        if (k != 32) begin n_err++; $display("FAIL gap done cycle: got %0d want 32", k); end
        if (last_acc != 16) begin n_err++; $display("FAIL gap acc: got %0d want 16", last_acc); end
    endtask

    task automatic test_len0;
        cyc(0, 1, 0, 0, 100, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        n_cmp += 2;
        if (!last_done) begin n_err++; $display("FAIL len0 done: got 0 want 1"); end
        if (last_acc != 0) begin n_err++; $display("FAIL len0 acc: got %0d want 0", last_acc); end
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
    endtask

    task automatic test_start_mid_run;
        int k;
        cyc(0, 1, $urandom_range(1), 20, $urandom_range(127), 1, 1, $urandom_range(127));
        for (k = 1; k <= 100; k++) begin
            cyc(0, k == 5, 1, 3, 0, 1, $urandom_range(1), $urandom_range(127));
            if (last_done) break;
        end
        n_cmp++;
        if (k != 21) begin n_err++; $display("FAIL midstart done cycle: got %0d want 21", k); end
    endtask

    task automatic test_back_to_back;
        int k;
        cyc(0, 1, 0, 8, 127, 1, 1, 5);
        for (k = 1; k <= 8; k++) cyc(0, 0, 0, 0, 0, 1, 1, 5);
        cyc(0, 1, 1, 5, 0, 1, 1, 5);
        n_cmp += 2;
        if (!last_done || last_acc != 8) begin
            n_err++; $display("FAIL b2b first: got done=%b acc=%0d want done=1 acc=8", last_done, last_acc);
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 5);
        if (!last_busy || last_acc != 0) begin
            n_err++; $display("FAIL b2b restart: got busy=%b acc=%0d want busy=1 acc=0", last_busy, last_acc);
        end
        for (k = 2; k <= 50; k++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 5);
            if (last_done) break;
        end
        n_cmp++;
        if (k != 6 || last_acc != 5) begin n_err++; $display("FAIL b2b second: got k=%0d acc=%0d want k=6 acc=5", k, last_acc); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        cyc(0, 1, 0, 128, 127, 1, 1, 3);
        for (int k = 1; k < 10; k++) cyc(0, 0, 0, 0, 0, 1, 1, 3);
        cyc(1, 0, 0, 0, 0, 1, 1, 3);
        n_cmp++;
        if ({last_busy, last_done, 8'(last_acc), 7'(last_rand)} !== {1'b1, 1'b0, 8'd9, 7'd3}) begin
            n_err++; $display("FAIL rstmid pre: got busy=%b acc=%0d want busy=1 acc=9", last_busy, last_acc);
        end
        cyc(0, 0, 0, 0, 0, 1, 1, 3);
        n_cmp++;
        if (last_busy || last_done || last_acc != 0 || last_rand != 0) begin
            n_err++; $display("FAIL rstmid post: got busy=%b done=%b acc=%0d rand=%0d want 0s", last_busy, last_done, last_acc, last_rand);
        end
        for (int k = 0; k < 140; k++) begin
            cyc(0, 0, 0, 0, 0, 1, 1, 3);
            seen += int'(last_done);
        end
        n_cmp++;
        if (seen != 0) begin n_err++; $display("FAIL rstmid done pulses: got %0d want 0", seen); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 300; n++)
            cyc(0, $urandom_range(7) == 0, $urandom_range(1), $urandom_range(12), $urandom_range(127),
                $urandom_range(3) != 0, $urandom_range(1), $urandom_range(127));
    endtask

    initial begin
        test_reset;
        test_unipolar;
        test_bipolar;
        test_enable_gaps;
        test_len0;
        test_start_mid_run;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mul_inner_acc.md
# mul_inner_acc

Parametrised, windowed successor of the unary rate-coded multiplier inner cell used in the systolic array. Each cycle it multiplies an incoming input bitstream by a binary weight by comparing the weight against a forwarded random number. It supports unipolar (AND) and bipolar (XNOR) modes and passes the random number to the neighbouring PE through a one-cycle register. It also counts output ones over a programmable stream window with a start/done handshake, so a PE can produce a binary partial product without an external counter.

## Interface
- WIDTH, 8: weight/random precision; weight and random buses are WIDTH-1 bits.
- LENW, WIDTH: width of the window-length input and of the output count.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_start  in  1  request a new window; accepted in IDLE or DONE only.
- i_mode  in  1  latched on accepted start: 0 = unipolar (AND), 1 = bipolar (XNOR).
- i_len  in  LENW  window length in enabled cycles, latched on accepted start.
- i_data_w  in  WIDTH-1  weight, latched on accepted start.
- i_en  in  1  stream-valid qualifier; 0 freezes the window.
- i_bit_i  in  1  input bitstream bit.
- i_randW  in  WIDTH-1  random number from the upstream PE.
- o_randW  out  WIDTH-1  registered copy of i_randW for the downstream PE.
- o_bit  out  1  product bitstream bit (combinational).
- o_busy  out  1  high in RUN.
- o_done  out  1  one-cycle pulse in DONE.
- o_acc  out  LENW  count of o_bit ones in the current or last window.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: o_randW=0, o_acc=0, o_busy=0, o_done=0. Latched w, mode and len are all 0.
- o_randW <= i_randW every cycle, regardless of state or i_en. This forwarding is the systolic pipeline.
- Weight bit: bitW = (w_lat > o_randW), an unsigned compare. It uses the registered random number, not i_randW.
- o_bit:
  - RUN and i_en=1, mode 0: i_bit_i & bitW.
  - RUN and i_en=1, mode 1: ~(i_bit_i ^ bitW).
  - All other cases: o_bit=0.
- IDLE: when i_start=1, latch w, mode and len, clear o_acc and cnt. Go to RUN if len≠0; if len=0, go straight to DONE.
- RUN:
  - i_start is ignored.
  - When i_en=1: acc <= acc + o_bit and cnt <= cnt + 1.
  - When i_en=1 and cnt == len-1: go to DONE.
  - When i_en=0: cnt, acc and state hold.
- DONE: o_done=1 and o_acc holds the final count.
  - i_start=1 in the same cycle: latch and clear as in IDLE, then go to RUN (or stay in DONE if the new len=0). This allows back-to-back windows with no idle cycle.
  - Otherwise go to IDLE.
- o_acc holds its value through IDLE until the next accepted start.
- Arithmetic: the count never exceeds len ≤ 2^LENW−1, so the LENW-bit accumulator cannot overflow. cnt is LENW bits.
- Bipolar decode (2·acc − len) is done downstream, not in this block.
- rst mid-window: the window is aborted, all outputs return to their reset values, and no o_done is produced.

## Timing
- o_randW: latency 1 cycle.
- o_bit: same cycle as i_bit_i, i_en and the current o_randW.
- Start accepted at edge t. RUN covers the next len enabled cycles. o_done is high in the cycle after the last enabled RUN cycle.
- With i_en held at 1, o_done is high in cycle t+len+1, and o_acc is valid in that same cycle.
- len=0: o_done is high in cycle t+1 with o_acc=0.
- o_busy is low in the DONE cycle.

## Test plan
- Unipolar: WIDTH=8, w=64, i_randW ramps 0..127, i_bit_i=1, len=128, i_en=1 → o_acc=64 when o_done pulses at t+129. o_randW lags i_randW by exactly 1 cycle.
- Bipolar: w=64, i_bit_i=0, same ramp, len=128 → o_acc=64 (XNOR is high where rand≥64). With i_bit_i=1 → 64. With w=0 and i_bit_i=0 → 128.
- Enable gaps: len=16, w=127, i_bit_i=1, i_en toggled 1,0,1,0… → o_done arrives after 32 cycles with o_acc=16. o_bit=0 on every i_en=0 cycle.
- Handshake edges:
  - len=0 → o_done the next cycle with o_acc=0.
  - i_start pulsed mid-RUN → ignored, count unaffected.
  - i_start in the DONE cycle → new window starts with no IDLE cycle, and o_acc clears.
- Reset mid-window: rst asserted on RUN cycle 10 of 128 → next cycle IDLE, o_acc=0, o_randW=0, and no o_done pulse.
